// File: rtl/crc_stream_if.sv
// Stream-in / result-out bundle for crc_stream: word stream with sof/eof framing,
// held result port, and the orphan pulse.
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 32,
    parameter int LEN_W  = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              s_eof;
    logic              m_valid;
    logic              m_ready;
    logic [CRC_W-1:0]  m_crc;
    logic [LEN_W-1:0]  m_len;
    logic              m_match;
    logic              orphan;

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, m_ready,
        output s_ready, m_valid, m_crc, m_len, m_match, orphan
    );

    modport master (
        output s_valid, s_data, s_sof, s_eof, m_ready,
        input  s_ready, m_valid, m_crc, m_len, m_match, orphan
    );
endinterface

// File: rtl/crc_stream.sv
// Word-parallel framed CRC engine: folds DATA_W bits per beat, holds CRC and word count
// until consumed. Define CRC_CHECK_EN to add the CHECK_VAL residue comparator on m_match.
module crc_stream #(
    parameter int          CRC_W  = 32,
    parameter int          DATA_W = 8,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
    parameter bit          REFIN  = 1'b1,
    parameter bit          REFOUT = 1'b1,
    parameter int          LEN_W  = 16
`ifdef CRC_CHECK_EN
    , parameter logic [31:0] CHECK_VAL = 32'h2144DF1C
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    crc_stream_if.slave  bus
);
    localparam logic [CRC_W-1:0] POLY_C   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_C = XOROUT[CRC_W-1:0];

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c,
                                              input logic [DATA_W-1:0] w);
        logic [CRC_W-1:0] r;
        logic             b;
        logic             d;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            b = REFIN ? w[i] : w[DATA_W-1-i];
            d = r[CRC_W-1] ^ b;
            r = {r[CRC_W-2:0], 1'b0};
            if (d) r = r ^ POLY_C;
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] rv;
        for (int i = 0; i < CRC_W; i++) rv[i] = c[CRC_W-1-i];
        return (REFOUT ? rv : c) ^ XOROUT_C;
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] l);
        return (l == {LEN_W{1'b1}}) ? l : l + LEN_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              m_valid_q, m_valid_d;
    logic [CRC_W-1:0]  m_crc_q, m_crc_d;
    logic [LEN_W-1:0]  m_len_q, m_len_d;
    logic              m_match_q, m_match_d;
    logic              orphan_q, orphan_d;

    logic              s_ready;
    logic              beat;
    logic              accept;
    logic [CRC_W-1:0]  fold_crc;
    logic [LEN_W-1:0]  fold_len;
    logic [CRC_W-1:0]  result;

    assign s_ready  = !m_valid_q || bus.m_ready;
    assign beat     = bus.s_valid && s_ready;
    // A sof beat always restarts, so a partial frame in RUN is silently discarded.
    assign accept   = beat && (bus.s_sof || (state_q == RUN));
    assign fold_crc = fold(bus.s_sof ? INIT_C : crc_q, bus.s_data);
    assign fold_len = bus.s_sof ? LEN_W'(1) : sat_inc(len_q);
    assign result   = finalize(fold_crc);

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        m_valid_d = m_valid_q && !bus.m_ready;
        m_crc_d   = m_crc_q;
        m_len_d   = m_len_q;
        m_match_d = m_match_q;
        orphan_d  = beat && !accept;
        if (accept) begin
            if (bus.s_eof) begin
                state_d   = IDLE;
                crc_d     = INIT_C;
                len_d     = '0;
                m_valid_d = 1'b1;
                m_crc_d   = result;
                m_len_d   = fold_len;
`ifdef CRC_CHECK_EN
                m_match_d = (result == CHECK_VAL[CRC_W-1:0]);
`else
                m_match_d = 1'b0;
`endif
            end else begin
                state_d = RUN;
                crc_d   = fold_crc;
                len_d   = fold_len;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT_C;
            len_q     <= '0;
            m_valid_q <= 1'b0;
            m_crc_q   <= '0;
            m_len_q   <= '0;
            m_match_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            m_valid_q <= m_valid_d;
            m_crc_q   <= m_crc_d;
            m_len_q   <= m_len_d;
            m_match_q <= m_match_d;
            orphan_q  <= orphan_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_crc   = m_crc_q;
    assign bus.m_len   = m_len_q;
    assign bus.m_match = m_match_q;
    assign bus.orphan  = orphan_q;
endmodule
